// File: rtl/dht22_sched_pkg.sv
// Shared types and helpers for the DHT22 read scheduler.
//   sched_state_t : scheduler FSM state encoding
//   ms_div()      : clocks per millisecond tick (never below 1)
//   STAT_W        : width of the optional statistics counters
package dht22_sched_pkg;

   localparam int STAT_W = 16;

   typedef enum logic [2:0] {IDLE, HOLDOFF, START, BUSY, DONE} sched_state_t;

   function automatic int ms_div(input int clk_freq);
      return (clk_freq / 1000 < 1) ? 1 : clk_freq / 1000;
   endfunction

endpackage

// File: rtl/dht22_ms_tick.sv
// Free-running millisecond prescaler. Down-counter reloaded with
// CLK_FREQ/1000-1; o_tick is high for one clock at terminal count.
// Ports:
//   i_clk   system clock
//   i_arst  asynchronous reset, active-high
//   o_tick  one-cycle pulse every CLK_FREQ/1000 clocks
module dht22_ms_tick
   import dht22_sched_pkg::*;
#(
   parameter int CLK_FREQ = 100000000
) (
   input  logic i_clk,
   input  logic i_arst,
   output logic o_tick
);

   localparam int DIV = ms_div(CLK_FREQ);
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst)
         r_cnt <= CW'(DIV - 1);
      else if (r_cnt == '0)
         r_cnt <= CW'(DIV - 1);
      else
         r_cnt <= r_cnt - CW'(1);
   end

   assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/dht22_read_scheduler.sv
// DHT22 read scheduler: shares one sensor reader among N_REQ level
// requesters and a periodic auto trigger. Enforces a minimum gap between
// start_read pulses, times out hung reads, retries CRC/timeout failures and
// acks every requester captured at the first attempt's start together.
// Optional feature macro: DHT22_SCHED_STATS_EN (ok/error statistics).
// Ports:
//   i_clk, i_arst          clock, asynchronous active-high reset
//   i_enable               0: no new reads start, pending auto trigger dropped
//   i_auto_en, i_period_s  periodic trigger enable / period in seconds
//   i_req / o_ack          level requests / one-cycle acks
//   o_start_read           one-cycle pulse to the reader
//   i_sys_idle             reader idle
//   i_data_ready, i_crc_err reader result (rising edge) and checksum status
//   o_busy                 FSM not idle
//   o_last_ok/o_last_tmo/o_last_retries  outcome of the last transaction
//   o_stat_ok_cnt/o_stat_err_cnt         saturating counters (macro), else 0
//
// state   | meaning
// IDLE    | no transaction; waiting for request or auto trigger
// HOLDOFF | waiting for the inter-read gap and an idle reader
// START   | one-cycle start_read pulse, counters cleared
// BUSY    | read in flight; waiting for data_ready or timeout
// DONE    | ack served requesters and publish the outcome
module dht22_read_scheduler
   import dht22_sched_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int N_REQ      = 2,
   parameter int MIN_GAP_S  = 2,
   parameter int TIMEOUT_MS = 50,
   parameter int MAX_RETRY  = 3,
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic              i_clk,
   input  logic              i_arst,
   input  logic              i_enable,
   input  logic              i_auto_en,
   input  logic [7:0]        i_period_s,
   input  logic [N_REQ-1:0]  i_req,
   output logic [N_REQ-1:0]  o_ack,
   output logic              o_start_read,
   input  logic              i_sys_idle,
   input  logic              i_data_ready,
   input  logic              i_crc_err,
   output logic              o_busy,
   output logic              o_last_ok,
   output logic              o_last_tmo,
   output logic [RW-1:0]     o_last_retries,
   output logic [STAT_W-1:0] o_stat_ok_cnt,
   output logic [STAT_W-1:0] o_stat_err_cnt
);

   localparam int GAP_MAX = MIN_GAP_S * 1000;
   localparam int GAP_W   = $clog2(GAP_MAX + 1);
   localparam int TMO_W   = $clog2(TIMEOUT_MS + 1);
   localparam int PER_W   = 18;

   sched_state_t      r_state, w_next;
   logic              w_tick;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic [TMO_W-1:0]  r_tmo_cnt;
   logic [PER_W-1:0]  r_per_cnt;
   logic [PER_W-1:0]  w_per_lim;
   logic [7:0]        w_per_s;
   logic              w_per_run, w_per_hit;
   logic              r_auto_pend;
   logic              r_dr_q;
   logic              w_dr_rise, w_gap_ok, w_tmo_hit, w_fail;
   logic [N_REQ-1:0]  r_served;
   logic [RW-1:0]     r_retry_cnt;
   logic              r_res_ok, r_res_tmo;

   dht22_ms_tick #(.CLK_FREQ(CLK_FREQ)) u_ms_tick (
      .i_clk  (i_clk),
      .i_arst (i_arst),
      .o_tick (w_tick)
   );

   assign w_gap_ok  = (r_gap_cnt == GAP_W'(GAP_MAX));
   assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_MS));
   assign w_dr_rise = i_data_ready & ~r_dr_q;
   assign w_fail    = (w_dr_rise & i_crc_err) | (~w_dr_rise & w_tmo_hit);

   // Short periods are clamped up to the sensor's minimum gap.
   assign w_per_s   = (i_period_s < 8'(MIN_GAP_S)) ? 8'(MIN_GAP_S) : i_period_s;
   assign w_per_lim = PER_W'(w_per_s) * PER_W'(1000);
   assign w_per_run = i_auto_en && (i_period_s != 8'd0) && i_enable;
   assign w_per_hit = w_per_run && w_tick && (r_per_cnt >= w_per_lim - PER_W'(1));

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_gap_cnt   <= '0;
         r_tmo_cnt   <= '0;
         r_per_cnt   <= '0;
         r_auto_pend <= 1'b0;
         r_dr_q      <= 1'b0;
      end else begin
         r_dr_q <= i_data_ready;

         if (r_state == START)
            r_gap_cnt <= '0;
         else if (w_tick && !w_gap_ok)
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);

         if (r_state == START)
            r_tmo_cnt <= '0;
         else if (r_state == BUSY && w_tick && !w_tmo_hit)
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

         if (!w_per_run || w_per_hit)
            r_per_cnt <= '0;
         else if (w_tick)
            r_per_cnt <= r_per_cnt + PER_W'(1);

         // A period elapsing in the START cycle belongs to the next read.
         if (!i_enable)
            r_auto_pend <= 1'b0;
         else if (w_per_hit)
            r_auto_pend <= 1'b1;
         else if (r_state == START)
            r_auto_pend <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if ((|i_req || r_auto_pend) && i_enable) w_next = HOLDOFF;
         HOLDOFF: if (w_gap_ok && i_sys_idle) w_next = START;
         START:   w_next = BUSY;
         BUSY: begin
            if (w_dr_rise && !i_crc_err)
               w_next = DONE;
            else if (w_fail)
               w_next = (r_retry_cnt < RW'(MAX_RETRY)) ? HOLDOFF : DONE;
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_served       <= '0;
         r_retry_cnt    <= '0;
         r_res_ok       <= 1'b0;
         r_res_tmo      <= 1'b0;
         o_last_ok      <= 1'b0;
         o_last_tmo     <= 1'b0;
         o_last_retries <= '0;
      end else begin
         unique case (r_state)
            START: begin
               // Retries keep the requester set captured on the first attempt.
               if (r_retry_cnt == '0)
                  r_served <= i_req;
            end
            BUSY: begin
               if (w_dr_rise && !i_crc_err) begin
                  r_res_ok  <= 1'b1;
                  r_res_tmo <= 1'b0;
               end else if (w_fail) begin
                  r_res_ok  <= 1'b0;
                  r_res_tmo <= ~w_dr_rise;
                  if (r_retry_cnt < RW'(MAX_RETRY))
                     r_retry_cnt <= r_retry_cnt + RW'(1);
               end
            end
            DONE: begin
               o_last_ok      <= r_res_ok;
               o_last_tmo     <= r_res_tmo;
               o_last_retries <= r_retry_cnt;
               r_retry_cnt    <= '0;
            end
            default: ;
         endcase
      end
   end

   assign o_start_read = (r_state == START);
   assign o_ack        = (r_state == DONE) ? r_served : '0;
   assign o_busy       = (r_state != IDLE);

`ifdef DHT22_SCHED_STATS_EN
   logic [STAT_W-1:0] r_stat_ok, r_stat_err;

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         r_stat_ok  <= '0;
         r_stat_err <= '0;
      end else if (r_state == DONE) begin
         if (r_res_ok && r_stat_ok != '1)
            r_stat_ok <= r_stat_ok + STAT_W'(1);
         if (!r_res_ok && r_stat_err != '1)
            r_stat_err <= r_stat_err + STAT_W'(1);
      end
   end

   assign o_stat_ok_cnt  = r_stat_ok;
   assign o_stat_err_cnt = r_stat_err;
`else
   assign o_stat_ok_cnt  = '0;
   assign o_stat_err_cnt = '0;
`endif

endmodule
